// File: rtl/inst_loader.sv
//==============================================================================
// inst_loader : host byte stream -> 32-bit fetcher load strobes, CPU held in reset until loaded
// Rev 1.0 | optional idle-byte timeout enabled by `define LOADER_TIMEOUT_EN
//==============================================================================
`default_nettype none

module inst_loader #(
  parameter int MAX_WORDS      = 256,
  parameter int LITTLE_ENDIAN  = 0,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        chip_select,
  output logic        fetcher_loading,
  output logic [31:0] fetcher_load_inst,
  output logic [15:0] load_addr,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] count;
  logic [1:0]  byte_cnt;
  logic [31:0] word;
  logic [31:0] word_next;
  logic [15:0] addr_inc;
  logic        xfer;
  logic        timeout;

  assign xfer     = byte_valid && (state == RECV);
  assign addr_inc = load_addr + 16'd1;

  generate
    if (LITTLE_ENDIAN != 0) begin : g_little
      assign word_next = {byte_data, word[31:8]};
    end else begin : g_big
      assign word_next = {word[23:0], byte_data};
    end
  endgenerate

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  // Restarts on every transfer and whenever RECV is (re)entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          idle_cnt <= '0;
    else if (state != RECV || xfer)   idle_cnt <= '0;
    else                              idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout = (state == RECV) && !xfer && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      byte_cnt  <= '0;
      word      <= '0;
      load_addr <= '0;
      cpu_rst   <= 1'b1;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count == 16'd0) begin
              load_addr <= '0;
              error     <= 1'b0;
              state     <= RELEASE;
            end else if (word_count > 16'(MAX_WORDS)) begin
              error <= 1'b1;
            end else begin
              count     <= word_count;
              load_addr <= '0;
              byte_cnt  <= '0;
              error     <= 1'b0;
              cpu_rst   <= 1'b1;
              state     <= RECV;
            end
          end
        end
        RECV: begin
          if (timeout) begin
            error <= 1'b1;
            state <= IDLE;
          end else if (xfer) begin
            word     <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= WRITE;
          end
        end
        WRITE: begin
          load_addr <= addr_inc;
          state     <= (addr_inc == count) ? RELEASE : RECV;
        end
        RELEASE: begin
          cpu_rst <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobe-side outputs decode straight from state so nothing reaches them from inputs
  assign byte_ready        = (state == RECV);
  assign chip_select       = (state == WRITE);
  assign fetcher_loading   = (state == WRITE);
  assign fetcher_load_inst = (state == WRITE) ? word : 32'd0;
  assign busy              = (state != IDLE);
  assign done              = (state == RELEASE);

endmodule

`default_nettype wire
